// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and selection helpers for the
// 8-line active-low event encoder.
package enc_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Index of the highest set bit; line 7 has the highest priority.
  function automatic logic [CODE_W-1:0] prio_sel(input logic [N_LINES-1:0] bitmap);
    logic [CODE_W-1:0] idx;
    idx = 3'd0;
    for (int i = 0; i < N_LINES; i++) begin
      if (bitmap[i]) begin
        idx = i[CODE_W-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // First set bit at or after last+1, ascending with wrap-around.
  // Scanning from the far end lets the nearest hit overwrite earlier ones.
  function automatic logic [CODE_W-1:0] rr_sel(input logic [N_LINES-1:0] bitmap,
                                                input logic [CODE_W-1:0]  last);
    logic [CODE_W-1:0] idx;
    logic [CODE_W-1:0] cand;
    idx = 3'd0;
    for (int k = N_LINES - 1; k >= 0; k--) begin
      cand = last + 3'd1 + k[CODE_W-1:0];
      if (bitmap[cand]) begin
        idx = cand;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/enc8_3_event_sync_edge.sv
// Per-line input synchronizer with falling-edge detection on the
// synchronized level; edges are only reported once real samples have flushed.
module sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_n_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [SYNC_STAGES:0]              vld_q;

  // vld_q marks which pipeline stages hold post-reset samples, so the
  // 8'hFF reset image can never be mistaken for a line that was high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {SYNC_STAGES{{WIDTH{1'b1}}}};
      prev_q <= {WIDTH{1'b1}};
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_n_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise_o = prev_q & ~sync_q[SYNC_STAGES-1] & {WIDTH{vld_q[SYNC_STAGES]}};

endmodule

// File: rtl/enc8_3_event.sv
// Active-low 8-to-3 event encoder with pending bitmap and VALID/READY output.
// Define ENC8_3_ROUND_ROBIN_EN for round-robin instead of fixed-priority selection.
module enc8_3_event
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N_LINES-1:0] y_n_i,
  input  logic               ready_i,
  output logic [CODE_W-1:0]  code_o,
  output logic               valid_o,
  output logic [N_LINES-1:0] pend_o,
  output logic               ovf_o
);

  logic [N_LINES-1:0] rise_s;
  logic [N_LINES-1:0] clr_s;
  logic [CODE_W-1:0]  sel_s;
  logic               load_s;

  state_t             state_q, state_d;
  logic [N_LINES-1:0] pend_q, pend_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (N_LINES)
  ) u_sync_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_n_i   (y_n_i),
    .rise_o  (rise_s)
  );

`ifdef ENC8_3_ROUND_ROBIN_EN
  logic [CODE_W-1:0] last_q, last_d;

  assign sel_s  = rr_sel(pend_q, last_q);
  assign last_d = load_s ? sel_s : last_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 3'd7;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign sel_s = prio_sel(pend_q);
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    load_s  = 1'b0;
    clr_s   = '0;
    case (state_q)
      IDLE: begin
        if (pend_q != 8'h00) begin
          load_s = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      PRESENT: begin
        if (ready_i) begin
          if (pend_q != 8'h00) begin
            load_s = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (load_s) begin
      code_d  = sel_s;
      valid_d = 1'b1;
      state_d = PRESENT;
      clr_s   = 8'h01 << sel_s;
    end else begin
      clr_s   = '0;
    end
    // A new edge beats the load-clear, so an edge on the just-loaded line stays pending.
    pend_d = (pend_q & ~clr_s) | rise_s;
    ovf_d  = |(rise_s & pend_q & ~clr_s);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pend_q  <= 8'h00;
      code_q  <= 3'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign code_o  = code_q;
  assign valid_o = valid_q;
  assign pend_o  = pend_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_enc8_3_event.sv
// Self-checking bench for enc8_3_event: directed scenarios plus random
// traffic, all compared against an event-level reference model.
module tb_enc8_3_event;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] y_n = 8'hFF;
  logic       ready = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pend;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  enc8_3_event #(.SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .y_n_i(y_n), .ready_i(ready),
    .code_o(code), .valid_o(valid), .pend_o(pend), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] yq[$];
  logic [7:0] m_pend;
  logic       m_valid;
  logic [2:0] m_code;
  logic       m_ovf;
  int         m_last;

  task automatic model_reset();
    yq.delete();
    m_pend = 8'h00; m_valid = 1'b0; m_code = 3'd0; m_ovf = 1'b0; m_last = 7;
  endtask

  function automatic int pick(input logic [7:0] bm, input int last);
    int r;
    r = -1;
`ifdef ENC8_3_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) if (r < 0 && bm[(last + k) % 8]) r = (last + k) % 8;
`else
    for (int k = 7; k >= 0; k--) if (r < 0 && bm[k]) r = k;
`endif
    return r;
  endfunction

  // A line falls S edges after the low sample is taken, provided the sample
  // before it was a real (post-reset) high.
  task automatic model_step();
    logic [7:0] fall;
    logic [7:0] clr;
    logic       accept;
    int         idx;
    yq.push_back(y_n);
    if (yq.size() > S + 2) void'(yq.pop_front());
    fall = (yq.size() == S + 2) ? (yq[0] & ~yq[1]) : 8'h00;
    accept = m_valid && ready;
    clr = 8'h00;
    if ((!m_valid || accept) && m_pend != 8'h00) begin
      idx = pick(m_pend, m_last);
      clr[idx] = 1'b1;
      m_code = idx[2:0];
      m_valid = 1'b1;
      m_last = idx;
    end else if (accept) begin
      m_valid = 1'b0;
    end
    m_ovf  = |(fall & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | fall;
  endtask

  function automatic logic [12:0] exp_vec();
    return {m_valid, m_valid ? m_code : 3'd0, m_pend, m_ovf};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {valid, valid ? code : 3'd0, pend, ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    y_n = 8'hFF; ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({valid, pend, ovf} !== 10'd0) begin
        errors++; $display("FAIL reset_idle cyc=%0d got v=%b p=%h o=%b want 0/00/0", i, valid, pend, ovf);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_model got=%h want=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    int nvalid;
    ready = 1'b1;
    y_n = 8'hDF;
    tick(); tick(); tick();
    checks++;
    if (pend !== 8'h20 || valid !== 1'b0) begin
      errors++; $display("FAIL single_pend got p=%h v=%b want 20/0", pend, valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || code !== 3'd5 || pend !== 8'h00) begin
      errors++; $display("FAIL single_latency got v=%b c=%0d p=%h want 1/5/00", valid, code, pend);
    end
    nvalid = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid) nvalid++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL single_model got=%h want=%h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (nvalid !== 1) begin
      errors++; $display("FAIL single_count got=%0d want=1", nvalid);
    end
    y_n = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_priority();
    logic [2:0] exp_seq[3];
`ifdef ENC8_3_ROUND_ROBIN_EN
    exp_seq = '{3'd1, 3'd3, 3'd6};
`else
    exp_seq = '{3'd6, 3'd3, 3'd1};
`endif
    do_reset();
    repeat (5) tick();
    ready = 1'b0;
    y_n = 8'hB5;
    repeat (6) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (valid !== 1'b1 || code !== exp_seq[k]) begin
        errors++; $display("FAIL prio_seq%0d got v=%b c=%0d want 1/%0d", k, valid, code, exp_seq[k]);
      end
      ready = 1'b1;
      tick();
    end
    checks++;
    if (valid !== 1'b0 || pend !== 8'h00) begin
      errors++; $display("FAIL prio_drain got v=%b p=%h want 0/00", valid, pend);
    end
    y_n = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_overflow();
    int novf;
    int n2;
    int budget;
    ready = 1'b0;
    y_n = 8'h7F; tick(); tick(); y_n = 8'hFF;
    budget = 0;
    while (!valid && budget < 10) begin tick(); budget++; end
    checks++;
    if (valid !== 1'b1 || code !== 3'd7) begin
      errors++; $display("FAIL ovf_slot got v=%b c=%0d want 1/7", valid, code);
    end
    novf = 0;
    for (int i = 0; i < 14; i++) begin
      y_n = (i < 2 || (i >= 4 && i < 6)) ? 8'hFB : 8'hFF;
      tick();
      if (ovf) novf++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL ovf_model got=%h want=%h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (novf !== 1 || pend !== 8'h04) begin
      errors++; $display("FAIL ovf_pulse got n=%0d p=%h want 1/04", novf, pend);
    end
    ready = 1'b1;
    n2 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid && code == 3'd2) n2++;
    end
    checks++;
    if (n2 !== 1 || valid !== 1'b0) begin
      errors++; $display("FAIL ovf_deliver got n2=%0d v=%b want 1/0", n2, valid);
    end
  endtask

  task automatic test_same_line();
    int novf;
    do_reset();
    repeat (5) tick();
    ready = 1'b0;
    y_n = 8'hEF; tick(); tick(); y_n = 8'hFF;
    repeat (4) tick();
    checks++;
    if (valid !== 1'b1 || code !== 3'd4) begin
      errors++; $display("FAIL same_first got v=%b c=%0d want 1/4", valid, code);
    end
    novf = 0;
    y_n = 8'hEF; tick(); if (ovf) novf++; tick(); if (ovf) novf++;
    y_n = 8'hFF;
    for (int i = 0; i < 4; i++) begin tick(); if (ovf) novf++; end
    checks++;
    if (pend !== 8'h10 || novf !== 0) begin
      errors++; $display("FAIL same_pend got p=%h n=%0d want 10/0", pend, novf);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b1 || code !== 3'd4 || pend !== 8'h00) begin
      errors++; $display("FAIL same_again got v=%b c=%0d p=%h want 1/4/00", valid, code, pend);
    end
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL same_model got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    ready = 1'b0;
    y_n = 8'h7F; tick(); tick(); y_n = 8'hFF;
    budget = 0;
    while (!valid && budget < 10) begin tick(); budget++; end
    y_n = 8'h7E; tick(); tick(); y_n = 8'hFF;
    repeat (4) tick();
    checks++;
    if (valid !== 1'b1 || code !== 3'd7 || pend !== 8'h81) begin
      errors++; $display("FAIL mid_setup got v=%b c=%0d p=%h want 1/7/81", valid, code, pend);
    end
    y_n = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, pend, ovf} !== 10'd0) begin
      errors++; $display("FAIL mid_async got v=%b p=%h o=%b want 0/00/0", valid, pend, ovf);
    end
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || pend !== 8'h00 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL mid_held_low got=%h want=%h", obs_vec(), exp_vec());
      end
    end
    y_n = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) y_n[b] = ~y_n[b];
      ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    y_n = 8'hFF; ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_drain got=%h want=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_overflow();
    test_same_line();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
